// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the ADD/ADDI/LW/SW/BEQ/BNE subset over a shared memory.
// Optional macro ILLEGAL_TRAP_EN: illegal decodes park in TRAP with a sticky illegal flag.
module multicycle_ctrl #(
    parameter int ALU_CTRL_WIDTH = 3,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                op,
    input  logic [2:0]                funct3,
    input  logic                      funct7b5,
    input  logic                      EQ,
    input  logic                      mem_ready,
    output logic                      PCWrite,
    output logic                      AdrSrc,
    output logic                      MemWrite,
    output logic                      IRWrite,
    output logic                      RegWrite,
    output logic [1:0]                ResultSrc,
    output logic [1:0]                ALUSrcA,
    output logic [1:0]                ALUSrcB,
    output logic [1:0]                ImmSrc,
    output logic [ALU_CTRL_WIDTH-1:0] ALUctrl,
    output logic [CNT_WIDTH-1:0]      retired,
    output logic                      illegal,
    output logic [3:0]                o_dbg_state
);

    // Handshake: mem_ready=1 in a cycle means the memory completes the pending
    // access in that cycle; the FSM holds its memory state (and strobes) until then.

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       cmp;
    } ctl_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    // Moore controls of a state; outputs are registered from the next state.
    function automatic ctl_t ctl_for(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.src_b = 2'b10; c.result_src = 2'b10; end
            S_DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
            S_MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            S_EXECR:    c.src_a = 2'b10;
            S_EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; end
            S_ALUWB:    c.reg_write = 1'b1;
            S_BRANCH:   begin c.src_a = 2'b10; c.cmp = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t               r_state;
    ctl_t                 r_ctl;
    logic [CNT_WIDTH-1:0] r_retired;

    state_t w_next;
    logic   w_retire;
    logic   w_is_mem;
    logic   w_is_r;
    logic   w_is_i;
    logic   w_is_br;
    logic   w_br_take;
`ifdef ILLEGAL_TRAP_EN
    logic   w_trap;
    logic   r_illegal;
`endif

    assign w_is_mem  = (op == OP_LW) || (op == OP_SW);
    assign w_is_r    = (op == OP_R) && (funct3 == 3'b000) && !funct7b5;
    assign w_is_i    = (op == OP_I) && (funct3 == 3'b000);
    assign w_is_br   = (op == OP_BR) && ((funct3 == 3'b000) || (funct3 == 3'b001));
    assign w_br_take = (funct3 == 3'b001) ? ~EQ : EQ;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_trap   = 1'b0;
`endif
        case (r_state)
            S_FETCH:   if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_mem)     w_next = S_MEMADR;
                else if (w_is_r)  w_next = S_EXECR;
                else if (w_is_i)  w_next = S_EXECI;
                else if (w_is_br) w_next = S_BRANCH;
                else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
                    w_trap = 1'b1;
`else
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
`endif
                end
            end
            S_MEMADR:  w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:   begin w_next = S_FETCH; w_retire = 1'b1; end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXECR:   w_next = S_ALUWB;
            S_EXECI:   w_next = S_ALUWB;
            S_ALUWB:   begin w_next = S_FETCH; w_retire = 1'b1; end
            S_BRANCH:  begin w_next = S_FETCH; w_retire = 1'b1; end
            S_TRAP:    w_next = S_TRAP;
            default:   w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ctl     <= ctl_for(S_FETCH);
            r_retired <= '0;
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_ctl   <= ctl_for(w_next);
            if (w_retire) r_retired <= r_retired + CNT_WIDTH'(1);
`ifdef ILLEGAL_TRAP_EN
            if (w_trap) r_illegal <= 1'b1;
`endif
        end
    end

    // The two Mealy strobes are gated by rst_n so nothing loads while held in reset.
    assign PCWrite = rst_n && (((r_state == S_FETCH) && mem_ready) ||
                               ((r_state == S_BRANCH) && w_br_take));
    assign IRWrite = rst_n && (r_state == S_FETCH) && mem_ready;

    assign AdrSrc      = r_ctl.adr_src;
    assign MemWrite    = r_ctl.mem_write;
    assign RegWrite    = r_ctl.reg_write;
    assign ResultSrc   = r_ctl.result_src;
    assign ALUSrcA     = r_ctl.src_a;
    assign ALUSrcB     = r_ctl.src_b;
    assign ALUctrl     = ALU_CTRL_WIDTH'(r_ctl.cmp);
    assign retired     = r_retired;
    assign o_dbg_state = r_state;

    always_comb begin
        ImmSrc = 2'b00;
        if (op == OP_SW)      ImmSrc = 2'b01;
        else if (op == OP_BR) ImmSrc = 2'b10;
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM that drives the other end of the ALU interface. It produces ALUctrl (000 = add, 001 = equality compare) and operand selects, and consumes the ALU's EQ flag to resolve branches. It sequences fetch, decode, execute, memory and writeback for the subset ADD, ADDI, LW, SW, BEQ and BNE over a shared instruction/data memory with a ready handshake. It sits between the instruction register, the datapath muxes and the register file write enable.

Parameters:
ALU_CTRL_WIDTH, 3, width of ALUctrl (matches the ALU's control input)
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  7  instruction[6:0] from the instruction register
funct3  input  3  instruction[14:12]
funct7b5  input  1  instruction[30]
EQ  input  1  ALU equality flag, valid only while ALUctrl = 001
mem_ready  input  1  memory completes the current access this cycle
PCWrite  output  1  PC register load enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register and OldPC load enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  result mux: 00 = ALUOut, 01 = read data, 10 = ALUResult
ALUSrcA  output  2  SrcA mux: 00 = PC, 01 = OldPC, 10 = rs1
ALUSrcB  output  2  SrcB mux: 00 = rs2, 01 = imm, 10 = constant 4
ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B
ALUctrl  output  ALU_CTRL_WIDTH  ALU operation
retired  output  CNT_WIDTH  count of completed instructions
illegal  output  1  illegal-instruction indicator

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset: state goes to FETCH, retired = 0, illegal = 0. While rst_n = 0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. Mux outputs take their FETCH values.
- Output style: all outputs not listed for a state are 0 in that state. Outputs are Moore except PCWrite/IRWrite in FETCH and PCWrite in BRANCH.
- ImmSrc is decoded combinationally from op in every state: SW gives 01, branch gives 10, everything else gives 00.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl=000, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUctrl=000, so ALUOut = OldPC + branch offset. Next state by op:
  - 0000011 (LW) or 0100011 (SW) → MEMADR.
  - 0110011 with funct3=000 and funct7b5=0 → EXECR.
  - 0010011 with funct3=000 → EXECI.
  - 1100011 with funct3 000 or 001 → BRANCH.
  - Anything else → illegal handling (see Optional Feature).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUctrl=000. Go to MEMREAD if op=LW, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH; retired increments.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held continuously until mem_ready=1. Then go to FETCH; retired increments.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUctrl=000. Go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUctrl=000. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH; retired increments.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUctrl=001, ResultSrc=00.
  - PCWrite = EQ when funct3=000, or ~EQ when funct3=001, in the same cycle (EQ is combinational from the ALU).
  - Go to FETCH; retired increments.
- Latency with mem_ready tied to 1: ADD/ADDI 4 cycles, LW 5, SW 4, branch 3.
- retired wraps from all-ones to 0 with no flag.
- rst_n asserted in any state: immediate return to FETCH. An in-flight MemWrite or RegWrite is dropped in that same cycle.
- ALUctrl values other than 000 and 001 are never driven.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an illegal decode goes to state TRAP and sets illegal=1 (sticky). In TRAP all write strobes are 0 and the FSM stays there until rst_n. retired does not increment.
- Undefined: an illegal decode is treated as a NOP. The FSM returns from DECODE to FETCH, retired increments, and illegal is tied to 0.

Test Plan:
- Reset, then release with mem_ready=1 and op=ADDI (0010011, funct3 000) → state sequence FETCH, DECODE, EXECI, ALUWB; RegWrite=1 only in cycle 4; retired=1.
- LW with mem_ready low for 3 cycles in MEMREAD → FSM holds MEMREAD 4 cycles; RegWrite and ResultSrc=01 for exactly 1 cycle afterwards; retired=1.
- BEQ with EQ=1 and BNE with EQ=1 → PCWrite=1 in the BRANCH cycle for BEQ, 0 for BNE; ALUctrl=001 in both.
- SW with mem_ready delayed 2 cycles → MemWrite high for 3 consecutive cycles with AdrSrc=1, then FETCH.
- op=1111111 → with ILLEGAL_TRAP_EN: illegal=1, stuck in TRAP, no strobes, retired unchanged. Without it: back to FETCH, retired+1.
- rst_n pulsed low during MEMWRITE → MemWrite drops asynchronously; after release, state is FETCH and retired=0.
